// File: rtl/mem_arbiter.sv
// Shares one pipelined, single-ported memory between I-cache fills, D-cache fills and D-cache
// write-through stores; streams fill beats back to the owning cache with their word index.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WORDS  = 8,
    localparam int unsigned WB    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [DATA_W-1:0] fill_data,
    output logic [WB-1:0]     fill_word,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              d_wr_ack,
    output logic              busy
);
    localparam int unsigned CW = WB + 1;
    localparam int unsigned BW = ADDR_W - WB - 1;
    localparam logic [CW-1:0] CntMax  = CW'(WORDS);
    localparam logic [CW-1:0] CntLast = CW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StFill} state_e;
    typedef enum logic {OwnI, OwnD} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    owner_e            grant;
    logic [BW-1:0]     blk_q, blk_d;
    logic [CW-1:0]     issue_q, issue_d;
    logic [CW-1:0]     recv_q, recv_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              beat;
    logic              last_beat;
    logic              unused_addr_bits;

    // Byte-within-block bits of the miss addresses never reach memory.
    assign unused_addr_bits = ^{i_addr[WB:0], d_addr[WB:0]};

    // Beats outside a fill are leftovers from before a reset and are dropped.
    assign beat      = (state_q == StFill) && mem_rvalid;
    assign last_beat = beat && (recv_q == CntLast);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        blk_d       = blk_q;
        issue_d     = issue_q;
        recv_d      = recv_q;
        mem_en_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        // Round-robin on a tie: the miss that was not served last wins.
        grant = (d_req && (!i_req || (last_q == OwnI))) ? OwnD : OwnI;

        unique case (state_q)
            StIdle: begin
                if (d_wr_req) begin
                    state_d     = StWrite;
                    mem_en_d    = 1'b1;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = d_wr_addr;
                    mem_wdata_d = d_wr_data;
                end else if (i_req || d_req) begin
                    state_d    = StFill;
                    owner_d    = grant;
                    last_d     = grant;
                    blk_d      = (grant == OwnD) ? d_addr[ADDR_W-1:WB+1] : i_addr[ADDR_W-1:WB+1];
                    mem_en_d   = 1'b1;
                    mem_addr_d = {blk_d, {WB{1'b0}}, 1'b0};
                    issue_d    = CW'(1);
                end
            end
            StWrite: begin
                state_d = StIdle;
            end
            StFill: begin
                if (issue_q < CntMax) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = {blk_q, issue_q[WB-1:0], 1'b0};
                    issue_d    = issue_q + CW'(1);
                end
                if (beat) begin
                    recv_d = recv_q + CW'(1);
                end
                if (last_beat) begin
                    state_d = StIdle;
                    issue_d = '0;
                    recv_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= OwnI;
            last_q      <= OwnI;
            blk_q       <= '0;
            issue_q     <= '0;
            recv_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            blk_q       <= blk_d;
            issue_q     <= issue_d;
            recv_q      <= recv_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign fill_data   = mem_rdata;
    assign fill_word   = recv_q[WB-1:0];
    assign i_fill_we   = beat && (owner_q == OwnI);
    assign d_fill_we   = beat && (owner_q == OwnD);
    assign i_fill_done = last_beat && (owner_q == OwnI);
    assign d_fill_done = last_beat && (owner_q == OwnD);
    assign d_wr_ack    = (state_q == StWrite);
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, hand-written corner sequences and random traffic checked
// against a transaction-timeline model of the arbiter plus a behavioural pipelined memory.
module tb_mem_arbiter;
    localparam int KNone = 0, KWrite = 1, KI = 2, KD = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_wr_req = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wr_addr = '0, d_wr_data = '0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;

    mem_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_wr_req   (d_wr_req),
        .d_wr_addr  (d_wr_addr),
        .d_wr_data  (d_wr_data),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .fill_data  (fill_data),
        .fill_word  (fill_word),
        .i_fill_we  (i_fill_we),
        .d_fill_we  (d_fill_we),
        .i_fill_done(i_fill_done),
        .d_fill_done(d_fill_done),
        .d_wr_ack   (d_wr_ack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Behavioural memory: word array plus an in-order return queue with a programmable delay.
    typedef struct {
        logic [15:0] data;
        int          due;
    } ret_t;
    logic [15:0] mem_arr [32768];
    ret_t        rq[$];
    int          mem_dly = 4;

    // Arbiter model: the current transaction as a kind plus its grant cycle and last busy cycle.
    int          m_kind = KNone, m_g = 0, m_end = 0, m_dly = 0, m_last = KI;
    logic [11:0] m_blk = '0;
    logic [15:0] m_waddr = '0, m_wdata = '0;

    int  mode = 0;
    bit  rand_on = 0, rand_dly = 0;

    // Observation log.
    int          n_iwe = 0, n_dwe = 0, n_idone = 0, n_ddone = 0, n_rv = 0;
    int          i_done_cyc = 0, ack_cyc = 0, rd0_cyc = 0;
    int          done_q[$];
    logic [15:0] w_addr = '0, w_data = '0;

    typedef struct {
        logic        i_req;
        logic        en;
        logic [15:0] addr;
        logic        we;
        logic [2:0]  word;
        logic        done;
        logic        busy;
    } row_t;
    row_t tbl [14];

    function automatic row_t mk(logic i, logic en, logic [15:0] a, logic we, logic [2:0] w,
                                logic dn, logic b);
        row_t r;
        r.i_req = i; r.en = en; r.addr = a; r.we = we; r.word = w; r.done = dn; r.busy = b;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit model_free();
        return (m_kind == KNone) || (cyc > m_end);
    endfunction

    task automatic model_grant();
        int owner;
        if (!rst_n || !model_free()) return;
        if (d_wr_req) begin
            m_kind = KWrite; m_g = cyc; m_end = cyc + 1;
            m_waddr = d_wr_addr; m_wdata = d_wr_data;
        end else if (i_req || d_req) begin
            if (i_req && d_req) owner = (m_last == KI) ? KD : KI;
            else                owner = d_req ? KD : KI;
            if (rand_dly) mem_dly = $urandom_range(1, 7);
            m_kind = owner; m_last = owner; m_g = cyc;
            m_blk  = (owner == KD) ? d_addr[15:4] : i_addr[15:4];
            m_dly  = mem_dly; m_end = cyc + 8 + mem_dly;
        end
    endtask

    task automatic check_cycle();
        logic e_busy, e_en, e_wr, e_ack, e_iwe, e_dwe, e_idone, e_ddone;
        logic [15:0] e_addr, e_wdata, e_data;
        logic [2:0] e_word;
        int k;
        e_busy = 0; e_en = 0; e_wr = 0; e_ack = 0; e_iwe = 0; e_dwe = 0; e_idone = 0;
        e_ddone = 0; e_addr = '0; e_wdata = '0; e_data = '0; e_word = '0;
        if (m_kind == KWrite && cyc == m_g + 1) begin
            e_busy = 1; e_en = 1; e_wr = 1; e_ack = 1; e_addr = m_waddr; e_wdata = m_wdata;
        end else if (m_kind == KI || m_kind == KD) begin
            if (cyc >= m_g + 1 && cyc <= m_end) e_busy = 1;
            if (cyc >= m_g + 1 && cyc <= m_g + 8) begin
                k = cyc - m_g - 1;
                e_en = 1; e_addr = {m_blk, k[2:0], 1'b0};
            end
            if (cyc >= m_g + 1 + m_dly && cyc <= m_end) begin
                k = cyc - m_g - 1 - m_dly;
                e_word = k[2:0];
                e_data = mem_arr[{m_blk, k[2:0]}];
                if (m_kind == KI) begin e_iwe = 1; e_idone = (k == 7); end
                else              begin e_dwe = 1; e_ddone = (k == 7); end
            end
        end
        chk("busy", busy, e_busy);
        chk("mem_en", mem_en, e_en);
        if (e_en) begin
            chk("mem_wr", mem_wr, e_wr);
            chk("mem_addr", mem_addr, e_addr);
            if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);
        end
        chk("d_wr_ack", d_wr_ack, e_ack);
        chk("i_fill_we", i_fill_we, e_iwe);
        chk("d_fill_we", d_fill_we, e_dwe);
        chk("i_fill_done", i_fill_done, e_idone);
        chk("d_fill_done", d_fill_done, e_ddone);
        if (e_iwe || e_dwe) begin
            chk("fill_word", fill_word, e_word);
            chk("fill_data", fill_data, e_data);
        end
        if (i_fill_we) n_iwe++;
        if (d_fill_we) n_dwe++;
        if (i_fill_done) begin n_idone++; done_q.push_back(KI); i_done_cyc = cyc; end
        if (d_fill_done) begin n_ddone++; done_q.push_back(KD); end
        if (d_wr_ack) ack_cyc = cyc;
        if (mem_en && mem_wr) begin w_addr = mem_addr; w_data = mem_wdata; end
        if (mem_en && !mem_wr && mem_addr[3:1] == 3'd0) rd0_cyc = cyc;
        if (mem_rvalid) n_rv++;
    endtask

    task automatic react();
        bit idrop, ddrop, wdrop;
        idrop = 0; ddrop = 0; wdrop = 0;
        if (mode == 0) return;
        if (i_req && i_fill_done) begin i_req = 0; idrop = 1; end
        if (d_req && d_fill_done) begin d_req = 0; ddrop = 1; end
        if (d_wr_req && d_wr_ack) begin d_wr_req = 0; wdrop = 1; end
        if (!rand_on) return;
        if (!i_req && !idrop && $urandom_range(0, 3) == 0) begin
            i_req = 1; i_addr = 16'($urandom);
        end
        if (!d_req && !ddrop && $urandom_range(0, 3) == 0) begin
            d_req = 1; d_addr = 16'($urandom);
        end
        if (!d_wr_req && !wdrop && $urandom_range(0, 5) == 0) begin
            d_wr_req = 1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
        end
    endtask

    task automatic tick();
        ret_t r;
        model_grant();
        @(posedge clk);
        cyc++;
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = r.data;
        end
        if (mem_en) begin
            if (mem_wr) mem_arr[mem_addr[15:1]] = mem_wdata;
            else begin
                r.data = mem_arr[mem_addr[15:1]];
                r.due  = cyc + mem_dly;
                rq.push_back(r);
            end
        end
        #1;
        check_cycle();
        react();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req = 0; d_req = 0; d_wr_req = 0;
        m_kind = KNone; m_last = KI;
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_fill_word", fill_word, 0);
        chk("rst_fill_we", {i_fill_we, d_fill_we}, 0);
        chk("rst_fill_done", {i_fill_done, d_fill_done}, 0);
        chk("rst_ack_busy", {d_wr_ack, busy}, 0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_until_idle(input int max);
        int n;
        n = 0;
        while ((i_req || d_req || d_wr_req || !model_free()) && n < max) begin
            tick();
            n++;
        end
        chk("idle_within_budget", n < max, 1);
    endtask

    initial begin
        int n, b_iwe, b_dwe, b_dd, b_rv, t;
        for (int i = 0; i < 32768; i++) mem_arr[i] = 16'($urandom);
        tbl[0]  = mk(1, 0, 16'h0000, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 16'h1230, 0, 0, 0, 1);
        tbl[2]  = mk(1, 1, 16'h1232, 0, 0, 0, 1);
        tbl[3]  = mk(1, 1, 16'h1234, 0, 0, 0, 1);
        tbl[4]  = mk(1, 1, 16'h1236, 0, 0, 0, 1);
        tbl[5]  = mk(1, 1, 16'h1238, 1, 0, 0, 1);
        tbl[6]  = mk(1, 1, 16'h123A, 1, 1, 0, 1);
        tbl[7]  = mk(1, 1, 16'h123C, 1, 2, 0, 1);
        tbl[8]  = mk(1, 1, 16'h123E, 1, 3, 0, 1);
        tbl[9]  = mk(1, 0, 16'h0000, 1, 4, 0, 1);
        tbl[10] = mk(1, 0, 16'h0000, 1, 5, 0, 1);
        tbl[11] = mk(1, 0, 16'h0000, 1, 6, 0, 1);
        tbl[12] = mk(1, 0, 16'h0000, 1, 7, 1, 1);
        tbl[13] = mk(0, 0, 16'h0000, 0, 0, 0, 0);

        #1;
        do_reset();

        // I fill of 0x1234 with a 4-cycle memory.
        mode = 0; mem_dly = 4; i_addr = 16'h1234;
        for (int k = 0; k < 14; k++) begin
            chk("tbl_mem_en", mem_en, tbl[k].en);
            if (tbl[k].en) chk("tbl_mem_addr", mem_addr, tbl[k].addr);
            chk("tbl_i_fill_we", i_fill_we, tbl[k].we);
            if (tbl[k].we) chk("tbl_fill_word", fill_word, tbl[k].word);
            chk("tbl_i_fill_done", i_fill_done, tbl[k].done);
            chk("tbl_busy", busy, tbl[k].busy);
            i_req = tbl[k].i_req;
            tick();
        end
        mode = 1;

        // Store arriving during an I fill waits for the fill to finish.
        i_req = 1; i_addr = 16'h2000;
        tick();
        d_wr_req = 1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
        run_until_idle(100);
        chk("wr_after_fill_gap", ack_cyc - i_done_cyc, 2);
        chk("wr_addr", w_addr, 16'h0040);
        chk("wr_data", w_data, 16'hBEEF);

        // Round-robin between simultaneous misses.
        do_reset();
        done_q.delete();
        i_req = 1; d_req = 1; i_addr = 16'h3000; d_addr = 16'h4000;
        run_until_idle(100);
        i_req = 1; d_req = 1; i_addr = 16'h3010; d_addr = 16'h4010;
        run_until_idle(100);
        chk("rr_count", done_q.size(), 4);
        chk("rr_first_d", done_q[0], KD);
        chk("rr_then_i", done_q[1], KI);
        chk("rr_repeat_d", done_q[2], KD);

        // Store beats a D miss raised in the same cycle.
        d_wr_req = 1; d_wr_addr = 16'h0100; d_wr_data = 16'h1357;
        d_req = 1; d_addr = 16'h5000;
        t = cyc;
        run_until_idle(100);
        chk("wr_first_ack", ack_cyc, t + 1);
        chk("d_fill_start", rd0_cyc, t + 3);

        // Reset at fill beat 3; leftover returns must be ignored.
        mem_dly = 4;
        i_req = 1; i_addr = 16'h1234;
        n = 0;
        tick();
        while (!(i_fill_we && fill_word == 3'd3) && n < 40) begin
            tick();
            n++;
        end
        chk("reach_beat3", n < 40, 1);
        do_reset();
        b_iwe = n_iwe; b_rv = n_rv;
        for (int k = 0; k < 6; k++) tick();
        chk("stale_rvalid_seen", n_rv > b_rv, 1);
        chk("stale_no_fill_we", n_iwe - b_iwe, 0);
        b_iwe = n_iwe;
        i_req = 1; i_addr = 16'h5678;
        run_until_idle(100);
        chk("refill_beats", n_iwe - b_iwe, 8);

        // Latency independence.
        for (int j = 0; j < 2; j++) begin
            mem_dly = (j == 0) ? 1 : 7;
            b_dwe = n_dwe; b_dd = n_ddone;
            d_req = 1; d_addr = 16'($urandom);
            run_until_idle(100);
            chk("dly_beats", n_dwe - b_dwe, 8);
            chk("dly_done", n_ddone - b_dd, 1);
        end

        // Random traffic.
        rand_on = 1; rand_dly = 1;
        for (int k = 0; k < 3000; k++) tick();
        rand_on = 0;
        run_until_idle(200);
        rand_dly = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
